// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcodes
// and the datapath mux/ALU select codes.
package mips_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADDR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXEC_R,
    RWB,
    EXEC_I,
    IWB,
    BRANCH,
    JUMP,
    HALTED
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDIU = 6'h09;

  typedef enum logic [1:0] {SRCB_REG, SRCB_FOUR, SRCB_IMM, SRCB_IMM_SH2} alusrcb_t;
  typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT}           aluop_t;
  typedef enum logic [1:0] {PCSRC_ALU, PCSRC_ALUOUT, PCSRC_JUMP}         pcsrc_t;

endpackage

// File: rtl/mips_mc_control_if.sv
// Control/status bundle between the multicycle control FSM (master) and the
// datapath/memory it sequences (slave).
interface mips_mc_control_if;
  logic [5:0] opcode;
  logic       waitrequest;
  logic       pc_zero;
  logic       IRWrite;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSource;
  logic       active;
  logic [3:0] state_o;

  modport master (
    input  opcode, waitrequest, pc_zero,
    output IRWrite, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, active, state_o
  );

  modport slave (
    output opcode, waitrequest, pc_zero,
    input  IRWrite, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, active, state_o
  );
endinterface

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM: FETCH -> DECODE -> execute states, stalling on
// memory waitrequest and halting when the PC reaches zero.
module mips_mc_control
  import mips_pkg::*;
(
  input logic               clk,
  input logic               reset,
  mips_mc_control_if.master bus
);

  state_t state_q, state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: begin
        if (bus.pc_zero)          state_d = HALTED;
        else if (!bus.waitrequest) state_d = DECODE;
      end
      DECODE: begin
        case (bus.opcode)
          OP_RTYPE:     state_d = EXEC_R;
          OP_LW, OP_SW: state_d = MEMADDR;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          OP_ADDIU:     state_d = EXEC_I;
          default:      state_d = FETCH;
        endcase
      end
      MEMADDR: begin
        if (bus.opcode == OP_LW)      state_d = MEMREAD;
        else if (bus.opcode == OP_SW) state_d = MEMWRITE;
        else                          state_d = FETCH;
      end
      MEMREAD:  if (!bus.waitrequest) state_d = MEMWB;
      MEMWRITE: if (!bus.waitrequest) state_d = FETCH;
      EXEC_R:   state_d = RWB;
      EXEC_I:   state_d = IWB;
      MEMWB, RWB, IWB, BRANCH, JUMP: state_d = FETCH;
      HALTED:   state_d = HALTED;
      default:  state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Outputs are decoded straight from the state so reset forces them quiet
  // immediately; IRWrite/PCWrite are gated by waitrequest within FETCH.
  always_comb begin
    bus.IRWrite     = 1'b0;
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = SRCB_REG;
    bus.ALUOp       = ALUOP_ADD;
    bus.PCSource    = PCSRC_ALU;
    bus.active      = 1'b1;
    bus.state_o     = state_q;
    if (!reset) begin
      case (state_q)
        FETCH: begin
          if (!bus.pc_zero) begin
            bus.MemRead = 1'b1;
            bus.ALUSrcB = SRCB_FOUR;
            bus.IRWrite = !bus.waitrequest;
            bus.PCWrite = !bus.waitrequest;
          end
        end
        DECODE:  bus.ALUSrcB = SRCB_IMM_SH2;
        MEMADDR: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = SRCB_IMM;
        end
        MEMREAD: begin
          bus.MemRead = 1'b1;
          bus.IorD    = 1'b1;
        end
        MEMWB: begin
          bus.RegWrite = 1'b1;
          bus.MemtoReg = 1'b1;
        end
        MEMWRITE: begin
          bus.MemWrite = 1'b1;
          bus.IorD     = 1'b1;
        end
        EXEC_R: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUOp   = ALUOP_FUNCT;
        end
        RWB: begin
          bus.RegWrite = 1'b1;
          bus.RegDst   = 1'b1;
        end
        EXEC_I: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = SRCB_IMM;
        end
        IWB: bus.RegWrite = 1'b1;
        BRANCH: begin
          bus.ALUSrcA     = 1'b1;
          bus.ALUOp       = ALUOP_SUB;
          bus.PCWriteCond = 1'b1;
          bus.PCSource    = PCSRC_ALUOUT;
        end
        JUMP: begin
          bus.PCWrite  = 1'b1;
          bus.PCSource = PCSRC_JUMP;
        end
        HALTED:  bus.active = 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mc_control.sv
// Self-checking bench for mips_mc_control: random instruction stream with
// random stalls, plus directed reset-abandon and halt scenarios.
module tb_mips_mc_control;
  import mips_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic       irw, pcw, pcwc, iord, mrd, mwr, m2r, rdst, rwr, srca;
    logic [1:0] srcb, aluop, pcsrc;
    logic       active;
  } obs_t;

  typedef struct {
    obs_t       o;
    logic       w;
    logic [5:0] op;
  } step_t;

  logic clk = 1'b0;
  logic reset;
  int unsigned compared = 0;
  int unsigned mismatched = 0;
  step_t exp_q[$];

  mips_mc_control_if bus ();

  mips_mc_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic obs_t sample();
    obs_t o;
    o.st = bus.state_o;   o.irw = bus.IRWrite;   o.pcw = bus.PCWrite;
    o.pcwc = bus.PCWriteCond; o.iord = bus.IorD; o.mrd = bus.MemRead;
    o.mwr = bus.MemWrite; o.m2r = bus.MemtoReg;  o.rdst = bus.RegDst;
    o.rwr = bus.RegWrite; o.srca = bus.ALUSrcA;  o.srcb = bus.ALUSrcB;
    o.aluop = bus.ALUOp;  o.pcsrc = bus.PCSource; o.active = bus.active;
    return o;
  endfunction

  function automatic obs_t quiet(input logic [3:0] st);
    obs_t o = '0;
    o.st = st;
    o.active = 1'b1;
    return o;
  endfunction

  task automatic push(input obs_t o, input logic w, input logic [5:0] op);
    step_t s;
    s.o = o; s.w = w; s.op = op;
    exp_q.push_back(s);
  endtask

  // Expected cycle-by-cycle behaviour of one instruction, from the per-state rules.
  task automatic plan_instr(input logic [5:0] op, input int unsigned fs, input int unsigned ms);
    obs_t o;
    o = quiet(FETCH); o.mrd = 1; o.srcb = 2'd1;
    for (int unsigned i = 0; i < fs; i++) push(o, 1'b1, op);
    o.irw = 1; o.pcw = 1;
    push(o, 1'b0, op);
    o = quiet(DECODE); o.srcb = 2'd3;
    push(o, 1'($urandom), op);
    if (op == 6'h23 || op == 6'h2B) begin
      o = quiet(MEMADDR); o.srca = 1; o.srcb = 2'd2;
      push(o, 1'($urandom), op);
      if (op == 6'h23) begin
        o = quiet(MEMREAD); o.mrd = 1; o.iord = 1;
        for (int unsigned i = 0; i < ms; i++) push(o, 1'b1, op);
        push(o, 1'b0, op);
        o = quiet(MEMWB); o.rwr = 1; o.m2r = 1;
        push(o, 1'($urandom), op);
      end else begin
        o = quiet(MEMWRITE); o.mwr = 1; o.iord = 1;
        for (int unsigned i = 0; i < ms; i++) push(o, 1'b1, op);
        push(o, 1'b0, op);
      end
    end else if (op == 6'h00) begin
      o = quiet(EXEC_R); o.srca = 1; o.aluop = 2'd2;
      push(o, 1'($urandom), op);
      o = quiet(RWB); o.rwr = 1; o.rdst = 1;
      push(o, 1'($urandom), op);
    end else if (op == 6'h09) begin
      o = quiet(EXEC_I); o.srca = 1; o.srcb = 2'd2;
      push(o, 1'($urandom), op);
      o = quiet(IWB); o.rwr = 1;
      push(o, 1'($urandom), op);
    end else if (op == 6'h04) begin
      o = quiet(BRANCH); o.srca = 1; o.aluop = 2'd1; o.pcwc = 1; o.pcsrc = 2'd1;
      push(o, 1'($urandom), op);
    end else if (op == 6'h02) begin
      o = quiet(JUMP); o.pcw = 1; o.pcsrc = 2'd2;
      push(o, 1'($urandom), op);
    end
  endtask

  task automatic check(input string tag, input obs_t exp);
    obs_t got;
    got = sample();
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Runs at most max_steps queued cycles, then discards the remainder.
  task automatic run_queue(input string tag, input int unsigned max_steps);
    step_t s;
    int unsigned n = 0;
    while (exp_q.size() > 0 && n < max_steps) begin
      s = exp_q.pop_front();
      @(negedge clk);
      bus.waitrequest = s.w;
      bus.opcode = s.op;
      #1 check(tag, s.o);
      n++;
    end
    exp_q.delete();
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    #1 check(tag, quiet(FETCH));
    @(negedge clk);
    #1 check(tag, quiet(FETCH));
    bus.waitrequest = 1'b1;
    bus.pc_zero = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    logic [5:0] ops [7];
    logic [5:0] op;
    obs_t o;
    ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2B; ops[3] = 6'h04;
    ops[4] = 6'h02; ops[5] = 6'h09; ops[6] = 6'h3F;

    reset = 1'b1;
    bus.opcode = '0;
    bus.waitrequest = 1'b1;
    bus.pc_zero = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 check("reset_state", quiet(FETCH));
    reset = 1'b0;

    plan_instr(6'h23, 0, 0); run_queue("lw_nostall", 100);
    plan_instr(6'h23, 3, 0); run_queue("fetch_stall3", 100);
    plan_instr(6'h2B, 0, 2); run_queue("sw_stall2", 100);
    plan_instr(6'h04, 0, 0); run_queue("beq", 100);
    plan_instr(6'h02, 0, 0); run_queue("jump", 100);
    plan_instr(6'h3F, 0, 0); run_queue("nop_opcode", 100);
    plan_instr(6'h00, 1, 0); run_queue("rtype", 100);
    plan_instr(6'h09, 0, 0); run_queue("addiu", 100);

    for (int i = 0; i < 60; i++) begin
      op = ($urandom_range(0, 7) == 7) ? 6'($urandom) : ops[$urandom_range(0, 6)];
      plan_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
      run_queue("random_instr", 100);
    end

    // Abandon a load while it is stalled in MEMREAD.
    plan_instr(6'h23, 0, 3);
    run_queue("lw_before_reset", 4);
    pulse_reset("reset_mid_memread");
    plan_instr(6'h00, 0, 0); run_queue("after_reset", 100);

    // pc_zero wins over waitrequest on entry to FETCH.
    @(negedge clk);
    bus.pc_zero = 1'b1;
    bus.waitrequest = 1'b1;
    #1 check("fetch_pc_zero", quiet(FETCH));
    o = '0;
    o.st = HALTED;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.pc_zero = 1'($urandom);
      bus.waitrequest = 1'($urandom);
      bus.opcode = 6'($urandom);
      #1 check("halted", o);
    end
    pulse_reset("reset_from_halt");
    plan_instr(6'h2B, 1, 1); run_queue("after_halt", 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
